wb_queue: RTL and testbench

Write-back queue in front of the multi-port register file. It accepts up to IN result writes per cycle from the execution units and buffers them in order in a circular queue. It drains up to WRITE entries per cycle onto the register file write ports, which use active-low enables. Writes to the same register are kept in program order, and writes to the hard-wired zero register are discarded.

---
 rtl/wb_queue.sv | 118 +++++++++++
 tb/tb_wb_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue feeding the register file write ports.
// Ports: clk, reset (sync, active-high). in_valid/in_addr/in_data carry IN result lanes.
// in_ready reports room for a full lane group. we_/waddr/wdata are the registered,
// active-low-enable write ports. count, empty and full report queue occupancy.
module wb_queue #(
  parameter int DATA     = 32,
  parameter int ADDR     = 5,
  parameter int IN       = 4,
  parameter int WRITE    = 4,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b1,
  localparam int CNT     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN-1:0]         in_valid,
  input  logic [ADDR*IN-1:0]    in_addr,
  input  logic [DATA*IN-1:0]    in_data,
  output logic                  in_ready,
  output logic [WRITE-1:0]      we_,
  output logic [ADDR*WRITE-1:0] waddr,
  output logic [DATA*WRITE-1:0] wdata,
  output logic [CNT-1:0]        count,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR-1:0]  mem_addr [DEPTH];
  logic [DATA-1:0]  mem_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic [IN-1:0]    keep;
  logic [PW-1:0]    slot [IN];
  logic [CNT-1:0]   nin;
  logic [CNT-1:0]   nin_eff;

  logic [WRITE-1:0] sel;
  logic [CNT-1:0]   ndrain;
  logic             stop;

  // Room is judged from the registered count only, so a full lane
  // group always fits regardless of how much drains this cycle.
  assign in_ready = (CNT'(DEPTH) - count) >= CNT'(IN);
  assign empty    = (count == '0);
  assign full     = (count == CNT'(DEPTH));
  assign nin_eff  = in_ready ? nin : '0;

  // Compact kept lanes: each kept lane lands at tail plus the number
  // of kept lanes below it.
  always_comb begin
    nin = '0;
    for (int i = 0; i < IN; i++) begin
      keep[i] = in_valid[i] &&
                !(ZERO_REG && (in_addr[i*ADDR +: ADDR] == '0));
      slot[i] = tail + nin[PW-1:0];
      if (keep[i]) nin = nin + CNT'(1);
    end
  end

  // Take head entries in order, stopping at the first one whose
  // address repeats an earlier selected entry. Selection is a prefix,
  // so every earlier candidate is an already selected entry.
  always_comb begin
    stop   = 1'b0;
    sel    = '0;
    ndrain = '0;
    for (int k = 0; k < WRITE; k++) begin
      if (!stop && (CNT'(k) < count)) begin
        for (int j = 0; j < k; j++) begin
          if (mem_addr[head + PW'(j)] == mem_addr[head + PW'(k)])
            stop = 1'b1;
        end
        if (!stop) begin
          sel[k] = 1'b1;
          ndrain = ndrain + CNT'(1);
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      we_   <= '1;
      waddr <= '0;
      wdata <= '0;
    end else begin
      head  <= head + ndrain[PW-1:0];
      tail  <= tail + nin_eff[PW-1:0];
      count <= count + nin_eff - ndrain;
      for (int k = 0; k < WRITE; k++) begin
        we_[k] <= !sel[k];
        waddr[k*ADDR +: ADDR] <= sel[k] ? mem_addr[head + PW'(k)] : '0;
        wdata[k*DATA +: DATA] <= sel[k] ? mem_data[head + PW'(k)] : '0;
      end
    end
  end

  // Storage needs no reset: only entries counted by count are read.
  always_ff @(posedge clk) begin
    if (!reset && in_ready) begin
      for (int i = 0; i < IN; i++) begin
        if (keep[i]) begin
          mem_addr[slot[i]] <= in_addr[i*ADDR +: ADDR];
          mem_data[slot[i]] <= in_data[i*DATA +: DATA];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: scoreboard bench for wb_queue.
// Drives lane groups, tracks accepted writes in order, checks every port write.
module tb_wb_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [19:0]  in_addr;
  logic [127:0] in_data;
  logic         in_ready;
  logic [3:0]   we_;
  logic [19:0]  waddr;
  logic [127:0] wdata;
  logic [3:0]   count;
  logic         empty;
  logic         full;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   acc   = 0;

  wb_queue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .we_(we_), .waddr(waddr), .wdata(wdata),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [19:0] a,
                       input logic [127:0] d);
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    if (in_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i]) acc++;
        if (v[i] && a[i*5 +: 5] != 5'd0)
          sb.push_back('{a: a[i*5 +: 5], d: d[i*32 +: 32]});
      end
    end
  endtask

  task automatic idle();
    drive(4'b0, 20'b0, 128'b0);
  endtask

  task automatic port(input int k, input logic [4:0] a, input logic [31:0] d);
    chk($sformatf("port%0d addr", k), 64'(waddr[k*5 +: 5]), 64'(a));
    chk($sformatf("port%0d data", k), 64'(wdata[k*32 +: 32]), 64'(d));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !empty) && n < 30) begin
      idle();
      n++;
    end
    chk("drain timeout", 64'(sb.size()), 64'd0);
  endtask

  // Every cycle: each enabled port must carry the next expected write,
  // enables form a prefix, no address repeats, flags track count.
  task automatic mon();
    ent_t e;
    logic [4:0] a;
    for (int k = 0; k < 4; k++) begin
      a = waddr[k*5 +: 5];
      if (!we_[k]) begin
        if (k > 0) chk("we_ prefix", 64'(we_[k-1]), 64'd0);
        for (int j = 0; j < k; j++)
          chk("same-cycle dup addr", 64'(waddr[j*5 +: 5] == a), 64'd0);
        if (sb.size() == 0) begin
          chk("stray write", 64'(a), 64'h1_0000);
        end else begin
          e = sb.pop_front();
          chk("write order", 64'({a, wdata[k*32 +: 32]}), 64'(e));
        end
      end else begin
        chk("idle port zero",
            64'({waddr[k*5 +: 5], wdata[k*32 +: 32]}), 64'd0);
      end
    end
    chk("count bound", 64'(count <= 4'd8), 64'd1);
    chk("in_ready rule", 64'(in_ready), 64'(count <= 4'd4));
    chk("full flag", 64'(full), 64'(count == 4'd8));
    chk("empty flag", 64'(empty), 64'(count == 4'd0));
  endtask

  always @(negedge clk) mon();

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = '0;
    in_addr  = '0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset we_", 64'(we_), 64'hf);
    chk("reset count", 64'(count), 64'd0);
    chk("reset empty", 64'(empty), 64'd1);
    chk("reset full", 64'(full), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Four distinct lanes drain together two cycles later.
    drive(4'b1111, {5'd3, 5'd2, 5'd1, 5'd31},
          {32'd3, 32'd2, 32'd1, 32'd31});
    idle();
    idle();
    chk("t1 we_", 64'(we_), 64'h0);
    port(0, 5'd31, 32'd31);
    port(1, 5'd1, 32'd1);
    port(2, 5'd2, 32'd2);
    port(3, 5'd3, 32'd3);
    idle();
    chk("t1 we_ after", 64'(we_), 64'hf);
    chk("t1 count", 64'(count), 64'd0);

    // Address 0 is dropped at enqueue.
    drive(4'b0011, {5'd0, 5'd0, 5'd4, 5'd0},
          {32'd0, 32'd0, 32'h10, 32'hdeadbeef});
    idle();
    chk("t2 count", 64'(count), 64'd1);
    idle();
    chk("t2 we_", 64'(we_), 64'he);
    port(0, 5'd4, 32'h10);
    wait_drain();

    // Same-register conflict splits the drain.
    drive(4'b0111, {5'd0, 5'd6, 5'd5, 5'd5},
          {32'd0, 32'h30, 32'h21, 32'h20});
    idle();
    idle();
    chk("t3 we_ first", 64'(we_), 64'he);
    port(0, 5'd5, 32'h20);
    idle();
    chk("t3 we_ second", 64'(we_), 64'hc);
    port(0, 5'd5, 32'h21);
    port(1, 5'd6, 32'h30);
    wait_drain();

    // Sustained full-width stream; pointers wrap several times.
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      logic [19:0]  a;
      logic [127:0] d;
      for (int i = 0; i < 4; i++) begin
        a[i*5 +: 5]   = 5'(((c * 4 + i) % 31) + 1);
        d[i*32 +: 32] = 32'(32'h1000 + c * 4 + i);
      end
      drive(4'b1111, a, d);
    end
    chk("t4 accepted", 64'(acc), 64'd40);
    wait_drain();

    // Repeated address: one write per cycle, backpressure rejects a group.
    drive(4'b1111, {5'd7, 5'd7, 5'd7, 5'd7},
          {32'h703, 32'h702, 32'h701, 32'h700});
    drive(4'b1111, {5'd7, 5'd7, 5'd7, 5'd7},
          {32'h707, 32'h706, 32'h705, 32'h704});
    drive(4'b1111, {5'd7, 5'd7, 5'd7, 5'd7},
          {32'hbad3, 32'hbad2, 32'hbad1, 32'hbad0});
    chk("t5 count peak", 64'(count), 64'd7);
    chk("t5 in_ready low", 64'(in_ready), 64'd0);
    chk("t5 we_ single", 64'(we_), 64'he);
    for (int k = 3; k <= 9; k++) begin
      idle();
      chk("t5 count step", 64'(count), 64'(9 - k));
      chk("t5 we_ single", 64'(we_), 64'he);
    end
    chk("t5 empty", 64'(empty), 64'd1);
    wait_drain();

    // Reset with entries queued discards everything.
    drive(4'b1111, {5'd9, 5'd9, 5'd9, 5'd9},
          {32'h903, 32'h902, 32'h901, 32'h900});
    drive(4'b1111, {5'd9, 5'd9, 5'd9, 5'd9},
          {32'h907, 32'h906, 32'h905, 32'h904});
    idle();
    idle();
    chk("t6 count before", 64'(count), 64'd6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    chk("t6 we_", 64'(we_), 64'hf);
    chk("t6 count", 64'(count), 64'd0);
    chk("t6 in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    repeat (6) idle();
    chk("t6 no stale", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
